// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer.
// Seeds, default widths and the controller state encoding.
package fib_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 6;

    localparam int F0 = 0;
    localparam int F1 = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fib_step.sv
// One Fibonacci recurrence step: next_b = a + b, truncated.
// The wrap flag is sticky along the series once any term truncated.
module fib_step
    import fib_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_wrap,
    input  logic             b_wrap,
    output logic [WIDTH-1:0] next_b,
    output logic             next_b_wrap
);

    logic carry;

    assign {carry, next_b} = {1'b0, a} + {1'b0, b};
    assign next_b_wrap     = carry | a_wrap | b_wrap;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Sequenced Fibonacci term streamer with valid/ready output,
// per-beat index/last/wrap flags, done pulse and sticky overflow.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_wrap,
    output logic             done,
    output logic             overflow
);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_wrap_q;
    logic             b_wrap_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;

    logic busy_q;
    logic valid_q;
    logic done_q;
    logic ovf_q;

    logic busy_d;
    logic valid_d;
    logic done_d;

    logic [WIDTH-1:0] sum;
    logic             sum_wrap;

    logic             load;
    logic             fire;
    logic             last_hit;
    logic [CNT_W-1:0] last_idx;

    fib_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a          (a_q),
        .b          (b_q),
        .a_wrap     (a_wrap_q),
        .b_wrap     (b_wrap_q),
        .next_b     (sum),
        .next_b_wrap(sum_wrap)
    );

    assign load     = (state_q == IDLE) & start;
    assign fire     = valid_q & out_ready;
    assign last_idx = cnt_q - CNT_W'(1);
    assign last_hit = (idx_q == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_terms != '0) ? EMIT : DONE;
                end
            end
            EMIT: begin
                if (fire && last_hit) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they
    // line up with the state they describe without output logic.
    always_comb begin
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == EMIT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= WIDTH'(F0);
            b_q      <= WIDTH'(F1);
            a_wrap_q <= 1'b0;
            b_wrap_q <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (1'b1)
                load: begin
                    a_q      <= WIDTH'(F0);
                    b_q      <= WIDTH'(F1);
                    a_wrap_q <= 1'b0;
                    b_wrap_q <= 1'b0;
                    idx_q    <= '0;
                    cnt_q    <= num_terms;
                end
                fire: begin
                    a_q      <= b_q;
                    b_q      <= sum;
                    a_wrap_q <= b_wrap_q;
                    b_wrap_q <= sum_wrap;
                    idx_q    <= idx_q + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Overflow survives IDLE so software can read it after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (load) begin
            ovf_q <= 1'b0;
        end else if (fire) begin
            ovf_q <= ovf_q | a_wrap_q;
        end
    end

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = a_q;
    assign out_idx   = idx_q;
    assign out_last  = valid_q & last_hit;
    assign out_wrap  = valid_q & a_wrap_q;
    assign done      = done_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl against a wide-integer
// Fibonacci model with directed and randomized runs.
module tb_fib_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  num_terms;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        out_wrap;
    logic        done;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] bd[$];
    int          bi[$];
    bit          bl[$];
    bit          bw[$];
    int          bcyc[$];
    int          done_cnt;
    int          done_cyc;
    int          busy_cnt;
    int          stall_err;
    int          extra_valid;
    bit          tmo;

    fib_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_terms(num_terms),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_last (out_last),
        .out_wrap (out_wrap),
        .done     (done),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True (untruncated) F(k); fits in 64 bits for k < 64.
    function automatic longint unsigned fib_true(input int k);
        longint unsigned x = 0;
        longint unsigned y = 1;
        longint unsigned t;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [15:0] exp_data(input int k);
        longint unsigned v;
        v = fib_true(k);
        return v[15:0];
    endfunction

    function automatic bit exp_wrap(input int k);
        return fib_true(k) > 64'd65535;
    endfunction

    // mode 0: ready always high; 1: pattern 1,0,0; 2: random.
    task automatic run_stream(input int n, input int mode, input int inj);
        bit seen_done;
        bit held;
        int post;
        logic [24:0] prev;
        bd.delete(); bi.delete(); bl.delete(); bw.delete(); bcyc.delete();
        done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        stall_err = 0; extra_valid = 0;
        seen_done = 0; held = 0; post = 0; prev = '0;
        @(negedge clk);
        start = 1'b1;
        num_terms = 6'(n);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = (c == inj);
            if (c == inj) num_terms = 6'd3;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (held && prev != {out_data, out_idx, out_last, out_wrap})
                    stall_err++;
                if (seen_done) begin
                    extra_valid++;
                end else if (out_ready) begin
                    bd.push_back(out_data);
                    bi.push_back(int'(out_idx));
                    bl.push_back(out_last);
                    bw.push_back(out_wrap);
                    bcyc.push_back(c);
                end
                held = !out_ready;
                prev = {out_data, out_idx, out_last, out_wrap};
            end else begin
                held = 0;
            end
            if (done) begin
                done_cnt++;
                if (!seen_done) done_cyc = c;
                seen_done = 1;
            end
            if (seen_done) begin
                post++;
                if (post > 4) break;
            end
        end
        tmo = !seen_done;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        num_terms = '0;
        out_ready = 1'b0;
        #3;
        n_cmp++;
        if ({busy, out_valid, out_last, out_wrap, done, overflow,
             out_data, out_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got busy=%b v=%b d=%0d i=%0d ovf=%b want all 0",
                     busy, out_valid, out_data, out_idx, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy, out_valid, done} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_idle got busy=%b v=%b done=%b want 000",
                     busy, out_valid, done);
        end
    endtask

    task automatic test_basic();
        run_stream(8, 0, -1);
        n_cmp++;
        if (tmo || bd.size() != 8) begin
            n_bad++;
            $display("FAIL basic_len got %0d tmo=%b want 8", bd.size(), tmo);
        end
        for (int k = 0; k < bd.size() && k < 8; k++) begin
            n_cmp++;
            if (bd[k] !== exp_data(k) || bi[k] != k || bl[k] !== (k == 7)
                || bcyc[k] != k) begin
                n_bad++;
                $display("FAIL basic_beat%0d got d=%0d i=%0d l=%b c=%0d want d=%0d i=%0d l=%b c=%0d",
                         k, bd[k], bi[k], bl[k], bcyc[k], exp_data(k), k, k == 7, k);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != 8) begin
            n_bad++;
            $display("FAIL basic_done got cnt=%0d cyc=%0d want cnt=1 cyc=8", done_cnt, done_cyc);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_ovf got %b want 0", overflow);
        end
    endtask

    task automatic test_backpressure();
        run_stream(5, 1, -1);
        n_cmp++;
        if (tmo || bd.size() != 5 || stall_err != 0) begin
            n_bad++;
            $display("FAIL bp_len got %0d stall_err=%0d want 5 and 0", bd.size(), stall_err);
        end
        for (int k = 0; k < bd.size() && k < 5; k++) begin
            n_cmp++;
            if (bd[k] !== exp_data(k) || bi[k] != k) begin
                n_bad++;
                $display("FAIL bp_beat%0d got d=%0d i=%0d want d=%0d i=%0d",
                         k, bd[k], bi[k], exp_data(k), k);
            end
        end
        n_cmp++;
        if (bcyc.size() == 5 && (done_cnt != 1 || done_cyc != bcyc[4] + 1)) begin
            n_bad++;
            $display("FAIL bp_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                     done_cnt, done_cyc, bcyc[4] + 1);
        end
    endtask

    task automatic test_overflow();
        run_stream(26, 0, -1);
        n_cmp++;
        if (tmo || bd.size() != 26) begin
            n_bad++;
            $display("FAIL ovf_len got %0d want 26", bd.size());
        end
        if (bd.size() == 26) begin
            n_cmp++;
            if (bd[24] !== 16'd46368 || bw[24] !== 1'b0) begin
                n_bad++;
                $display("FAIL ovf_beat24 got d=%0d w=%b want 46368 0", bd[24], bw[24]);
            end
            n_cmp++;
            if (bd[25] !== 16'd9489 || bw[25] !== 1'b1) begin
                n_bad++;
                $display("FAIL ovf_beat25 got d=%0d w=%b want 9489 1", bd[25], bw[25]);
            end
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_sticky got ovf=%b busy=%b want 1 0", overflow, busy);
        end
    endtask

    task automatic test_edge_counts();
        run_stream(0, 0, -1);
        n_cmp++;
        if (tmo || bd.size() != 0 || done_cyc != 0 || done_cnt != 1 || busy_cnt != 1) begin
            n_bad++;
            $display("FAIL zero_run got beats=%0d dcyc=%0d dcnt=%0d busy=%0d want 0 0 1 1",
                     bd.size(), done_cyc, done_cnt, busy_cnt);
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_ovf_clear got %b want 0", overflow);
        end
        run_stream(1, 2, -1);
        n_cmp++;
        if (tmo || bd.size() != 1 || (bd.size() == 1 && (bd[0] !== 16'd0 || bl[0] !== 1'b1))) begin
            n_bad++;
            $display("FAIL one_run got beats=%0d want one beat d=0 last=1", bd.size());
        end
    endtask

    task automatic test_ignored_start();
        run_stream(8, 0, 3);
        n_cmp++;
        if (tmo || bd.size() != 8 || extra_valid != 0 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL ign_start got beats=%0d extra=%0d dcnt=%0d want 8 0 1",
                     bd.size(), extra_valid, done_cnt);
        end
        n_cmp++;
        if (bd.size() == 8 && (bd[7] !== 16'd13 || bl[7] !== 1'b1)) begin
            n_bad++;
            $display("FAIL ign_last got d=%0d l=%b want 13 1", bd[7], bl[7]);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        found = 0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        num_terms = 6'd8;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (out_valid && out_idx == 6'd4) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL arst_reach got found=0 want idx 4 reached");
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, out_valid, out_last, out_wrap, done, overflow,
             out_data, out_idx} !== '0) begin
            n_bad++;
            $display("FAIL arst_outputs got busy=%b v=%b d=%0d i=%0d want all 0",
                     busy, out_valid, out_data, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(3, 0, -1);
        n_cmp++;
        if (tmo || bd.size() != 3 ||
            (bd.size() == 3 && (bd[0] !== 16'd0 || bd[1] !== 16'd1 || bd[2] !== 16'd1))) begin
            n_bad++;
            $display("FAIL arst_rerun got beats=%0d want 0,1,1", bd.size());
        end
    endtask

    task automatic test_random();
        int  n;
        bit  any_wrap;
        for (int r = 0; r < 8; r++) begin
            n = (r < 2) ? $urandom_range(26, 63) : $urandom_range(0, 63);
            run_stream(n, 2, -1);
            any_wrap = 0;
            for (int k = 0; k < n; k++) any_wrap |= exp_wrap(k);
            n_cmp++;
            if (tmo || bd.size() != n || stall_err != 0 || done_cnt != 1) begin
                n_bad++;
                $display("FAIL rand%0d_run got beats=%0d stall=%0d dcnt=%0d want %0d 0 1",
                         r, bd.size(), stall_err, done_cnt, n);
            end
            for (int k = 0; k < bd.size() && k < n; k++) begin
                n_cmp++;
                if (bd[k] !== exp_data(k) || bi[k] != k || bl[k] !== (k == n - 1)
                    || bw[k] !== exp_wrap(k)) begin
                    n_bad++;
                    $display("FAIL rand%0d_beat%0d got d=%0d i=%0d l=%b w=%b want d=%0d i=%0d l=%b w=%b",
                             r, k, bd[k], bi[k], bl[k], bw[k],
                             exp_data(k), k, k == n - 1, exp_wrap(k));
                end
            end
            n_cmp++;
            if (overflow !== any_wrap) begin
                n_bad++;
                $display("FAIL rand%0d_ovf got %b want %b", r, overflow, any_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_edge_counts();
        test_ignored_start();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
